gf180_latch_rf_wr_ctrl: RTL
===========================

Name: gf180_latch_rf_wr_ctrl

Overview:
- Write sequencer and arbiter for a latch-based register bank built from gf180mcu 9t latch cells (transparent-high enable, active-high clear).
- Shares the bank between NREQ requesters using round-robin arbitration.
- Sequences each write as setup, one-hot enable pulse, then hold, so latch data never changes while an enable is high.
- Also issues a bank-wide clear. Sits between pipeline write ports and the latch array.

Parameters:
- NREQ, 2, number of write requesters (>=1).
- DEPTH, 8, number of latch words; AW = $clog2(DEPTH), minimum 1.
- WIDTH, 32, word width in bits.
- HOLD_CYC, 1, cycles lat_d stays stable after the enable pulse (>=1).

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant; a transfer occurs when valid&ready.
- req_addr  in  NREQ*AW  word address; requester i uses bits [i*AW +: AW].
- req_data  in  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- clr_req  in  1  level request to clear the whole bank.
- clr_ack  out  1  one-cycle pulse, coincident with lat_clr.
- lat_d  out  WIDTH  shared data bus to the latch D inputs.
- lat_en  out  DEPTH  one-hot latch enables (latch CK pins).
- lat_clr  out  1  bank clear (latch C pins).
- busy  out  1  high when state != IDLE.
- err_oob  out  1  one-cycle pulse when an accepted address is >= DEPTH.
- wr_count  out  16  completed-write counter (see Optional Feature).

Behaviour:
- Clock and reset are fixed: one clock, CK; reset RN is synchronous and active-low.
- Reset (RN=0 at a CK edge):
  - state=IDLE, rr_ptr=0.
  - lat_d, lat_en, lat_clr, clr_ack, err_oob and wr_count all go to 0.
  - req_ready=0 while RN=0.
  - Reset mid-sequence aborts the write: lat_en is 0 after that edge and no completion is counted.
- FSM states: IDLE, CLEAR, SETUP, PULSE, HOLD.
- IDLE:
  - If clr_req=1: all req_ready=0 and next state is CLEAR. Clear has priority over writes.
  - Else if any req_valid: req_ready is asserted combinationally for the round-robin winner only. The winner is the first valid index at or after rr_ptr, searching upward with wrap.
  - On the transfer: capture addr and data, set rr_ptr = winner+1 mod NREQ, go to SETUP.
  - req_ready is 0 in every state except IDLE.
- CLEAR: lat_clr=1 and clr_ack=1 for exactly one cycle, lat_en=0, then IDLE. If clr_req is still high, a new CLEAR follows.
- SETUP: lat_d = captured data, lat_en=0, one cycle.
  - If addr >= DEPTH: err_oob pulses this cycle, no enable pulse is issued, next state is IDLE, and the write is not counted.
- PULSE: lat_en[addr]=1 for exactly one cycle; lat_d unchanged.
- HOLD: lat_en=0 and lat_d unchanged for HOLD_CYC cycles, then IDLE. The write completes at the HOLD to IDLE transition.
- lat_d holds its last value in IDLE and CLEAR; it changes only on entry to SETUP.
- Latency: transfer in cycle T, then SETUP at T+1, PULSE at T+2, HOLD at T+3..T+2+HOLD_CYC. The earliest next transfer is at T+3+HOLD_CYC.
- Invariants:
  - lat_en is never non-zero in two consecutive cycles.
  - lat_en and lat_clr are never high together.
  - lat_d never changes in a cycle where lat_en != 0.
- clr_req raised during SETUP, PULSE or HOLD is serviced at the next IDLE; the write in progress finishes first.
- A requester that drops req_valid before being granted is simply skipped; there is no penalty.

Optional Feature:
- Macro: GF180_RF_WRCNT_EN.
- Defined: wr_count increments by 1 on every completed write and saturates at 16'hFFFF. It is not cleared by a CLEAR, only by RN.
- Undefined: wr_count is tied to 16'h0000 and no counter flops are instantiated.

Test Plan:
- Write, HOLD_CYC=1: RN deasserted, req0 valid with addr=3, data=32'hDEADBEEF -> req_ready[0]=1 at T; lat_d=DEADBEEF from T+1; lat_en=8'b0000_1000 only at T+2; busy=0 at T+4; wr_count=1 (macro on).
- Round-robin: both requesters continuously valid (req0 addr=1, req1 addr=2) -> grants go 0,1,0,1; lat_en pulses on words 1,2,1,2; each transfer is 4 cycles after the previous one.
- Clear priority: clr_req=1 and req0 valid in the same IDLE cycle -> lat_clr=1 and clr_ack=1 for 1 cycle, req_ready=0; the write is granted in the following cycle.
- Out of range, DEPTH=6: addr=7 accepted -> err_oob pulse at T+1, lat_en stays 0, busy=0 at T+2, wr_count unchanged.
- Reset mid-write: RN=0 during PULSE -> after that edge lat_en=0, state IDLE, lat_d=0, wr_count=0; the first grant after release goes to req0.
- Saturation (macro on): force 65535 completed writes, then one more -> wr_count=16'hFFFF. With the macro off, wr_count=0 throughout.

Source files
------------

// File: rtl/gf180_latch_rf_wr_ctrl.sv
// rtl/gf180_latch_rf_wr_ctrl.sv - round-robin write sequencer for a gf180 latch register bank
// Optional completed-write counter: define GF180_RF_WRCNT_EN.
module gf180_latch_rf_wr_ctrl #(
    parameter int NREQ     = 2,
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 32,
    parameter int HOLD_CYC = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  clr_req,
    output logic                  clr_ack,
    output logic [WIDTH-1:0]      lat_d,
    output logic [DEPTH-1:0]      lat_en,
    output logic                  lat_clr,
    output logic                  busy,
    output logic                  err_oob,
    output logic [15:0]           wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETUP, S_PULSE, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic             lat_clr_q, lat_clr_d;
    logic             err_oob_q, err_oob_d;

    logic [PW-1:0]    win;
    logic             found;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    logic [DEPTH-1:0] onehot;
    logic             take;
    logic             hold_done;

    // Two passes: first valid index at or above rr_ptr, else first valid from 0 (wrap).
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (PW'(i) >= rr_ptr_q)) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign take = RN && (state_q == S_IDLE) && !clr_req && found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = take && (PW'(i) == win);
        end
        for (int i = 0; i < DEPTH; i++) begin
            onehot[i] = (addr_q == AW'(i));
        end
    end

    assign hold_done = (hold_cnt_q == HW'(HOLD_CYC - 1));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        lat_d_d    = lat_d_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                end else if (take) begin
                    state_d  = S_SETUP;
                    addr_d   = win_addr;
                    lat_d_d  = win_data;
                    rr_ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                end
            end
            S_CLEAR: state_d = S_IDLE;
            S_SETUP: begin
                state_d    = err_oob_q ? S_IDLE : S_PULSE;
                hold_cnt_d = '0;
            end
            S_PULSE: state_d = S_HOLD;
            S_HOLD: begin
                if (hold_done) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Enables and clear come straight from flops so the latch pins never see decode glitches.
        lat_en_d  = (state_d == S_PULSE) ? onehot : '0;
        lat_clr_d = (state_d == S_CLEAR);
        err_oob_d = take && ({1'b0, win_addr} >= (AW + 1)'(DEPTH));
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            lat_d_q    <= '0;
            hold_cnt_q <= '0;
            lat_en_q   <= '0;
            lat_clr_q  <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            lat_d_q    <= lat_d_d;
            hold_cnt_q <= hold_cnt_d;
            lat_en_q   <= lat_en_d;
            lat_clr_q  <= lat_clr_d;
            err_oob_q  <= err_oob_d;
        end
    end

    assign lat_d   = lat_d_q;
    assign lat_en  = lat_en_q;
    assign lat_clr = lat_clr_q;
    assign clr_ack = lat_clr_q;
    assign err_oob = err_oob_q;
    assign busy    = (state_q != S_IDLE);

`ifdef GF180_RF_WRCNT_EN
    logic [15:0] wr_cnt_q;
    logic        complete;

    assign complete = (state_q == S_HOLD) && hold_done;

    always_ff @(posedge CK) begin
        if (!RN) begin
            wr_cnt_q <= '0;
        end else if (complete && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign wr_count = wr_cnt_q;
`else
    assign wr_count = 16'h0000;
`endif

endmodule
